// File: rtl/vc_switch_core.sv
// Packet switch core: a main FIFO feeds NUM_VC virtual-channel FIFOs, and a round-robin
// arbiter drains those into NUM_DEST output FIFOs. A control FSM manages thresholds, idle/active state and sticky errors.
module vc_switch_core #(
  parameter int DATA_SIZE  = 6,
  parameter int NUM_VC     = 2,
  parameter int NUM_DEST   = 2,
  parameter int MAIN_DEPTH = 8,
  parameter int VC_DEPTH   = 16,
  parameter int D_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init,
  input  logic                          push_main,
  input  logic [DATA_SIZE-1:0]          data_in,
  input  logic [NUM_DEST-1:0]           pop_d,
  input  logic [$clog2(MAIN_DEPTH):0]   cfg_af_main,
  input  logic [$clog2(VC_DEPTH):0]     cfg_af_vc,
  input  logic [$clog2(D_DEPTH):0]      cfg_af_d,
  output logic                          pause_main,
  output logic [NUM_DEST-1:0]           empty_d,
  output logic [NUM_DEST*DATA_SIZE-1:0] data_out,
  output logic [NUM_DEST-1:0]           valid_out,
  output logic [NUM_VC+NUM_DEST:0]      error_out,
  output logic                          active_out,
  output logic                          idle_out
);
  localparam int VCW = $clog2(NUM_VC);
  localparam int DW  = $clog2(NUM_DEST);
  localparam int MAW = $clog2(MAIN_DEPTH);
  localparam int VAW = $clog2(VC_DEPTH);
  localparam int DAW = $clog2(D_DEPTH);

  typedef enum logic [2:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;
  state_t state_reg, state_next;

  logic [MAW:0] af_main_reg;
  logic [VAW:0] af_vc_reg;
  logic [DAW:0] af_d_reg;
  logic [NUM_VC+NUM_DEST:0] error_reg, err_new;
  logic                     err_main;
  logic [NUM_VC-1:0]        err_vc;
  logic [NUM_DEST-1:0]      err_d;

  // Main FIFO (head read combinationally so a word can move on the next edge)
  logic [DATA_SIZE-1:0] main_mem [MAIN_DEPTH];
  logic [MAW-1:0]       main_wr_reg, main_rd_reg;
  logic [MAW:0]         main_cnt_reg;
  logic                 main_empty, main_full, main_pop, main_wr, push_ok;
  logic [DATA_SIZE-1:0] main_head;
  logic [VCW-1:0]       main_vc;

  logic [DATA_SIZE-1:0] vc_head [NUM_VC];
  logic [DW-1:0]        vc_dest [NUM_VC];
  logic [VAW:0]         vc_cnt  [NUM_VC];
  logic [NUM_VC-1:0]    vc_full, vc_empty, vc_push, vc_pop, vc_elig;
  logic [DAW:0]         d_cnt   [NUM_DEST];
  logic [NUM_DEST-1:0]  d_full;

  logic                 grant_valid;
  logic [VCW-1:0]       grant_idx, arb_idx, ptr_reg;
  logic [DW-1:0]        grant_dest;
  logic [DATA_SIZE-1:0] grant_word;

  assign push_ok    = push_main && (state_reg == ST_IDLE || state_reg == ST_ACTIVE);
  assign main_empty = (main_cnt_reg == '0);
  assign main_full  = (main_cnt_reg == (MAW+1)'(MAIN_DEPTH));
  assign main_head  = main_mem[main_rd_reg];
  assign main_vc    = main_head[DATA_SIZE-1 -: VCW];
  assign main_pop   = !main_empty && (vc_cnt[main_vc] < af_vc_reg) && !vc_full[main_vc];
  assign main_wr    = push_ok && (!main_full || main_pop);
  assign err_main   = push_ok && main_full && !main_pop;

  always_ff @(posedge clk) begin
    if (main_wr) main_mem[main_wr_reg] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_wr_reg  <= '0;
      main_rd_reg  <= '0;
      main_cnt_reg <= '0;
    end else begin
      if (main_wr)  main_wr_reg <= main_wr_reg + 1'b1;
      if (main_pop) main_rd_reg <= main_rd_reg + 1'b1;
      case ({main_wr, main_pop})
        2'b10:   main_cnt_reg <= main_cnt_reg + 1'b1;
        2'b01:   main_cnt_reg <= main_cnt_reg - 1'b1;
        default: main_cnt_reg <= main_cnt_reg;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    logic [DATA_SIZE-1:0] mem [VC_DEPTH];
    logic [VAW-1:0]       wr_reg, rd_reg;
    logic [VAW:0]         cnt_reg;
    logic                 wr_en;

    assign vc_push[gi]  = main_pop && (main_vc == VCW'(gi));
    assign vc_pop[gi]   = grant_valid && (grant_idx == VCW'(gi));
    assign vc_full[gi]  = (cnt_reg == (VAW+1)'(VC_DEPTH));
    assign vc_empty[gi] = (cnt_reg == '0);
    assign vc_cnt[gi]   = cnt_reg;
    assign wr_en        = vc_push[gi] && (!vc_full[gi] || vc_pop[gi]);
    assign err_vc[gi]   = vc_push[gi] && vc_full[gi] && !vc_pop[gi];
    assign vc_head[gi]  = mem[rd_reg];
    assign vc_dest[gi]  = vc_head[gi][DATA_SIZE-1-VCW -: DW];
    assign vc_elig[gi]  = !vc_empty[gi] && (d_cnt[vc_dest[gi]] < af_d_reg) && !d_full[vc_dest[gi]];

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_reg] <= main_head;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_reg  <= '0;
        rd_reg  <= '0;
        cnt_reg <= '0;
      end else begin
        if (wr_en)      wr_reg <= wr_reg + 1'b1;
        if (vc_pop[gi]) rd_reg <= rd_reg + 1'b1;
        case ({wr_en, vc_pop[gi]})
          2'b10:   cnt_reg <= cnt_reg + 1'b1;
          2'b01:   cnt_reg <= cnt_reg - 1'b1;
          default: cnt_reg <= cnt_reg;
        endcase
      end
    end
  end

  // Round-robin: first eligible VC scanning upward from the pointer, wrapping
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    arb_idx     = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      arb_idx = ptr_reg + VCW'(i);
      if (!grant_valid && vc_elig[arb_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = arb_idx;
      end
    end
  end

  assign grant_dest = vc_dest[grant_idx];
  assign grant_word = vc_head[grant_idx];

  always_ff @(posedge clk) begin
    if (reset)            ptr_reg <= '0;
    else if (grant_valid) ptr_reg <= grant_idx + VCW'(1);
  end

  for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_dest
    logic [DATA_SIZE-1:0] mem [D_DEPTH];
    logic [DAW-1:0]       wr_reg, rd_reg;
    logic [DAW:0]         cnt_reg;
    logic [DATA_SIZE-1:0] dout_reg;
    logic                 vld_reg, push, pop, wr_en;

    assign push        = grant_valid && (grant_dest == DW'(gi));
    assign pop         = pop_d[gi] && (cnt_reg != '0);
    assign err_d[gi]   = pop_d[gi] && (cnt_reg == '0);
    assign d_full[gi]  = (cnt_reg == (DAW+1)'(D_DEPTH));
    assign d_cnt[gi]   = cnt_reg;
    assign wr_en       = push && (!d_full[gi] || pop);
    assign empty_d[gi] = (cnt_reg == '0);
    assign data_out[gi*DATA_SIZE +: DATA_SIZE] = dout_reg;
    assign valid_out[gi] = vld_reg;

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_reg] <= grant_word;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_reg   <= '0;
        rd_reg   <= '0;
        cnt_reg  <= '0;
        dout_reg <= '0;
        vld_reg  <= 1'b0;
      end else begin
        vld_reg <= pop;
        if (pop) dout_reg <= mem[rd_reg];
        if (wr_en) wr_reg <= wr_reg + 1'b1;
        if (pop)   rd_reg <= rd_reg + 1'b1;
        case ({wr_en, pop})
          2'b10:   cnt_reg <= cnt_reg + 1'b1;
          2'b01:   cnt_reg <= cnt_reg - 1'b1;
          default: cnt_reg <= cnt_reg;
        endcase
      end
    end
  end

  assign err_new = {err_d, err_vc, err_main};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET: state_next = ST_INIT;
      ST_INIT:  if (!init) state_next = ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        if (init) state_next = ST_INIT;
        else if (main_empty && (&vc_empty) && (&empty_d)) state_next = ST_IDLE;
        else state_next = ST_ACTIVE;
      end
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_RESET;
    endcase
    if ((|err_new) || (|error_reg)) state_next = ST_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_RESET;
      error_reg   <= '0;
      af_main_reg <= (MAW+1)'(MAIN_DEPTH);
      af_vc_reg   <= (VAW+1)'(VC_DEPTH);
      af_d_reg    <= (DAW+1)'(D_DEPTH);
    end else begin
      state_reg <= state_next;
      error_reg <= error_reg | err_new;
      if (state_reg == ST_INIT && init) begin
        af_main_reg <= cfg_af_main;
        af_vc_reg   <= cfg_af_vc;
        af_d_reg    <= cfg_af_d;
      end
    end
  end

  assign pause_main = (main_cnt_reg >= af_main_reg);
  assign error_out  = error_reg;
  assign active_out = (state_reg == ST_ACTIVE);
  assign idle_out   = (state_reg == ST_IDLE);
endmodule

// File: tb/tb_vc_switch_core.sv
// Directed testbench for vc_switch_core with default parameters (2 VCs, 2 destinations).
module tb_vc_switch_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init = 1'b0;
  logic        push_main = 1'b0;
  logic [5:0]  data_in = '0;
  logic [1:0]  pop_d = '0;
  logic [3:0]  cfg_af_main = 4'd8;
  logic [4:0]  cfg_af_vc = 5'd16;
  logic [2:0]  cfg_af_d = 3'd4;
  logic        pause_main;
  logic [1:0]  empty_d;
  logic [11:0] data_out;
  logic [1:0]  valid_out;
  logic [4:0]  error_out;
  logic        active_out;
  logic        idle_out;

  int tests = 0;
  int failed = 0;
  logic [5:0] exp_words [6];

  always #5 clk = ~clk;

  vc_switch_core dut (
    .clk(clk), .reset(reset), .init(init), .push_main(push_main), .data_in(data_in),
    .pop_d(pop_d), .cfg_af_main(cfg_af_main), .cfg_af_vc(cfg_af_vc), .cfg_af_d(cfg_af_d),
    .pause_main(pause_main), .empty_d(empty_d), .data_out(data_out), .valid_out(valid_out),
    .error_out(error_out), .active_out(active_out), .idle_out(idle_out)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; init = 1'b0; push_main = 1'b0; pop_d = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic do_init(input logic [3:0] m, input logic [4:0] v, input logic [2:0] d);
    cfg_af_main = m; cfg_af_vc = v; cfg_af_d = d;
    init = 1'b1;
    tick(); tick();
    init = 1'b0;
    tick();
  endtask

  task automatic push_word(input logic [5:0] w);
    push_main = 1'b1; data_in = w;
    tick();
    push_main = 1'b0;
    $display("[TB] push 0x%02h", w);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    tests++; if (pause_main !== 1'b0) begin failed++; $display("FAIL reset_pause got %b want 0", pause_main); end
    tests++; if (empty_d !== 2'b11) begin failed++; $display("FAIL reset_empty got %b want 11", empty_d); end
    tests++; if (data_out !== 12'h000) begin failed++; $display("FAIL reset_data got %h want 000", data_out); end
    tests++; if (valid_out !== 2'b00) begin failed++; $display("FAIL reset_valid got %b want 00", valid_out); end
    tests++; if (error_out !== 5'b00000) begin failed++; $display("FAIL reset_error got %b want 00000", error_out); end
    tests++; if ({active_out, idle_out} !== 2'b00) begin failed++; $display("FAIL reset_state got %b want 00", {active_out, idle_out}); end
    reset = 1'b0;
    tick();
    tests++; if ({active_out, idle_out} !== 2'b00) begin failed++; $display("FAIL init_state got %b want 00", {active_out, idle_out}); end
    $display("[TB] reset checks done");
  endtask

  task automatic test_single_word;
    do_reset();
    do_init(4'd6, 5'd12, 3'd3);
    tests++; if (idle_out !== 1'b1) begin failed++; $display("FAIL sw_idle_start got %b want 1", idle_out); end
    push_word(6'b101101);
    tests++; if (empty_d !== 2'b11) begin failed++; $display("FAIL sw_empty_e0 got %b want 11", empty_d); end
    tick();
    tests++; if (empty_d !== 2'b11) begin failed++; $display("FAIL sw_empty_e1 got %b want 11", empty_d); end
    tick();
    tests++; if (empty_d !== 2'b10) begin failed++; $display("FAIL sw_empty_e2 got %b want 10", empty_d); end
    tests++; if (active_out !== 1'b1) begin failed++; $display("FAIL sw_active got %b want 1", active_out); end
    pop_d = 2'b01;
    tick();
    pop_d = 2'b00;
    $display("[TB] pop d0 data=%b valid=%b", data_out[5:0], valid_out);
    tests++; if (data_out[5:0] !== 6'b101101) begin failed++; $display("FAIL sw_data got %b want 101101", data_out[5:0]); end
    tests++; if (valid_out !== 2'b01) begin failed++; $display("FAIL sw_valid got %b want 01", valid_out); end
    tick();
    tests++; if (valid_out !== 2'b00) begin failed++; $display("FAIL sw_valid_drop got %b want 00", valid_out); end
    tests++; if (data_out[5:0] !== 6'b101101) begin failed++; $display("FAIL sw_data_hold got %b want 101101", data_out[5:0]); end
    tests++; if (idle_out !== 1'b1) begin failed++; $display("FAIL sw_idle_end got %b want 1", idle_out); end
  endtask

  task automatic test_round_robin;
    exp_words[0] = 6'b000001; exp_words[1] = 6'b100001;
    exp_words[2] = 6'b000010; exp_words[3] = 6'b100010;
    exp_words[4] = 6'b000011; exp_words[5] = 6'b100011;
    do_reset();
    do_init(4'd8, 5'd16, 3'd0);
    for (int k = 0; k < 6; k++) push_word(exp_words[k]);
    tick(); tick(); tick();
    tests++; if (empty_d !== 2'b11) begin failed++; $display("FAIL rr_blocked got %b want 11", empty_d); end
    do_init(4'd8, 5'd16, 3'd4);
    for (int k = 0; k < 5; k++) tick();
    tests++; if (empty_d !== 2'b10) begin failed++; $display("FAIL rr_loaded got %b want 10", empty_d); end
    pop_d = 2'b01;
    for (int k = 0; k < 6; k++) begin
      tick();
      $display("[TB] pop d0 #%0d data=%b valid=%b", k, data_out[5:0], valid_out);
      tests++;
      if (data_out[5:0] !== exp_words[k] || valid_out !== 2'b01) begin
        failed++;
        $display("FAIL rr_order_%0d got %b/%b want %b/01", k, data_out[5:0], valid_out, exp_words[k]);
      end
    end
    pop_d = 2'b00;
    tick();
    tests++; if (empty_d !== 2'b11) begin failed++; $display("FAIL rr_drained got %b want 11", empty_d); end
    tests++; if (error_out !== 5'b00000) begin failed++; $display("FAIL rr_error got %b want 00000", error_out); end
  endtask

  task automatic test_dest_backpressure;
    do_reset();
    do_init(4'd8, 5'd16, 3'd2);
    for (int k = 0; k < 5; k++) push_word(6'b010000 + 6'(k));
    push_word(6'b100111);
    for (int k = 0; k < 12; k++) tick();
    tests++; if (empty_d !== 2'b00) begin failed++; $display("FAIL bp_both_loaded got %b want 00", empty_d); end
    do_init(4'd8, 5'd16, 3'd0);
    pop_d = 2'b10;
    tick();
    $display("[TB] pop d1 data=%b", data_out[11:6]);
    tests++; if (data_out[11:6] !== 6'b010000) begin failed++; $display("FAIL bp_d1_first got %b want 010000", data_out[11:6]); end
    tick();
    pop_d = 2'b00;
    $display("[TB] pop d1 data=%b", data_out[11:6]);
    tests++; if (data_out[11:6] !== 6'b010001) begin failed++; $display("FAIL bp_d1_second got %b want 010001", data_out[11:6]); end
    tests++; if (empty_d !== 2'b10) begin failed++; $display("FAIL bp_d1_held_two got %b want 10", empty_d); end
    pop_d = 2'b01;
    tick();
    pop_d = 2'b00;
    $display("[TB] pop d0 data=%b", data_out[5:0]);
    tests++; if (data_out[5:0] !== 6'b100111) begin failed++; $display("FAIL bp_d0_drained got %b want 100111", data_out[5:0]); end
    tests++; if (error_out !== 5'b00000) begin failed++; $display("FAIL bp_error got %b want 00000", error_out); end
  endtask

  task automatic test_main_overflow;
    do_reset();
    do_init(4'd6, 5'd0, 3'd4);
    for (int j = 1; j <= 9; j++) begin
      push_word(6'(j));
      if (j == 5) begin
        tests++; if (pause_main !== 1'b0) begin failed++; $display("FAIL ov_pause_5 got %b want 0", pause_main); end
      end
      if (j == 6) begin
        tests++; if (pause_main !== 1'b1) begin failed++; $display("FAIL ov_pause_6 got %b want 1", pause_main); end
      end
      if (j == 8) begin
        tests++; if (error_out !== 5'b00000) begin failed++; $display("FAIL ov_err_8 got %b want 00000", error_out); end
      end
    end
    tests++; if (error_out !== 5'b00001) begin failed++; $display("FAIL ov_err_9 got %b want 00001", error_out); end
    tests++; if ({active_out, idle_out} !== 2'b00) begin failed++; $display("FAIL ov_state got %b want 00", {active_out, idle_out}); end
    tests++; if (empty_d !== 2'b11) begin failed++; $display("FAIL ov_stalled got %b want 11", empty_d); end
  endtask

  task automatic test_underflow;
    do_reset();
    do_init(4'd8, 5'd16, 3'd4);
    pop_d = 2'b10;
    tick();
    pop_d = 2'b00;
    tests++; if (error_out !== 5'b10000) begin failed++; $display("FAIL uf_error got %b want 10000", error_out); end
    tests++; if (valid_out !== 2'b00) begin failed++; $display("FAIL uf_valid got %b want 00", valid_out); end
    tests++; if ({active_out, idle_out} !== 2'b00) begin failed++; $display("FAIL uf_state got %b want 00", {active_out, idle_out}); end
  endtask

  task automatic test_reset_mid_traffic;
    logic [3:0] iv;
    do_reset();
    do_init(4'd8, 5'd16, 3'd4);
    for (int i = 0; i < 10; i++) begin
      iv = 4'(i);
      push_word({iv[0], iv[1], iv + 4'd1});
    end
    tick(); tick();
    pop_d = 2'b01;
    tick();
    pop_d = 2'b00;
    tests++; if (data_out[5:0] !== 6'b000001 || valid_out !== 2'b01) begin failed++; $display("FAIL mt_pop got %b/%b want 000001/01", data_out[5:0], valid_out); end
    tests++; if (empty_d !== 2'b00) begin failed++; $display("FAIL mt_loaded got %b want 00", empty_d); end
    reset = 1'b1;
    tick();
    tests++; if (empty_d !== 2'b11) begin failed++; $display("FAIL mt_empty got %b want 11", empty_d); end
    tests++; if (data_out !== 12'h000 || valid_out !== 2'b00) begin failed++; $display("FAIL mt_data got %h/%b want 000/00", data_out, valid_out); end
    tests++; if ({pause_main, error_out, active_out, idle_out} !== 8'h00) begin failed++; $display("FAIL mt_flags got %b want 00000000", {pause_main, error_out, active_out, idle_out}); end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_dest_backpressure();
    test_main_overflow();
    test_underflow();
    test_reset_mid_traffic();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
